// File: rtl/tmp101_pkg.sv
// Shared constants, pointer codes, reset values and FSM state type for the
// TMP101 I2C responder.
package tmp101_pkg;

   localparam logic [6:0]  TMP101_ADDR_BASE = 7'b1001000;

   localparam logic [1:0]  PTR_TEMP  = 2'd0;
   localparam logic [1:0]  PTR_CONF  = 2'd1;
   localparam logic [1:0]  PTR_TLOW  = 2'd2;
   localparam logic [1:0]  PTR_THIGH = 2'd3;

   localparam logic [7:0]  CONF_RESET  = 8'h00;
   localparam logic [15:0] TLOW_RESET  = 16'h4B00;
   localparam logic [15:0] THIGH_RESET = 16'h5000;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ADDR     = 3'd1,
      ST_ADDR_ACK = 3'd2,
      ST_RX_BYTE  = 3'd3,
      ST_RX_ACK   = 3'd4,
      ST_TX_BYTE  = 3'd5,
      ST_TX_ACK   = 3'd6
   } state_e;

   // Byte index 0 selects the MSB of a 16-bit register, index 1 the LSB.
   function automatic logic [7:0] reg_byte(input logic [15:0] word, input logic idx);
      if (idx) begin
         reg_byte = word[7:0];
      end else begin
         reg_byte = word[15:8];
      end
   endfunction

endpackage

// File: rtl/tmp101_i2c_responder_if.sv
// I2C pad-side bundle: SCL/SDA pad inputs and the SDA tristate control.
interface tmp101_i2c_responder_if;

   logic scl_i;
   logic sda_i;
   logic sda_t;

   modport master (output scl_i, output sda_i, input sda_t);
   modport slave  (input scl_i, input sda_i, output sda_t);

endinterface

// File: rtl/i2c_bus_cond.sv
// Synchronizes and glitch-filters SCL/SDA, then derives registered edge,
// START and STOP strobes from the filtered levels only.
module i2c_bus_cond #(
   parameter int FILTER_LEN = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_det_o,
   output logic stop_det_o
);

   localparam int CW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

   // Bit 0 carries SCL, bit 1 carries SDA.
   logic [1:0]         raw_s;
   logic [1:0]         sync1_q, sync2_q;
   logic [1:0]         filt_q, filt_d;
   logic [1:0][CW-1:0] cnt_q, cnt_d;
   logic               scl_rise_q, scl_fall_q, start_q, stop_q;

   assign raw_s = {sda_i, scl_i};

   // A new level is accepted only after FILTER_LEN consecutive differing samples.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] != filt_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               filt_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end else begin
            cnt_d[i] = '0;
         end
      end
   end

   // Synchronizer, filter state and strobe registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q    <= 2'b11;
         sync2_q    <= 2'b11;
         filt_q     <= 2'b11;
         cnt_q      <= '0;
         scl_rise_q <= 1'b0;
         scl_fall_q <= 1'b0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
      end else begin
         sync1_q    <= raw_s;
         sync2_q    <= sync1_q;
         filt_q     <= filt_d;
         cnt_q      <= cnt_d;
         scl_rise_q <= filt_d[0] & ~filt_q[0];
         scl_fall_q <= ~filt_d[0] & filt_q[0];
         start_q    <= filt_q[0] & filt_d[0] & filt_q[1] & ~filt_d[1];
         stop_q     <= filt_q[0] & filt_d[0] & ~filt_q[1] & filt_d[1];
      end
   end

   assign sda_o       = filt_q[1];
   assign scl_rise_o  = scl_rise_q;
   assign scl_fall_o  = scl_fall_q;
   assign start_det_o = start_q;
   assign stop_det_o  = stop_q;

endmodule

// File: rtl/tmp101_i2c_responder.sv
// I2C target emulating a TMP101 (temperature/config/T_LOW/T_HIGH registers).
// Optional comparator-mode alert output is enabled by defining TMP101_ALERT_EN.
module tmp101_i2c_responder
   import tmp101_pkg::*;
#(
   parameter logic [2:0] I2C_ADDR   = 3'b000,
   parameter int         FILTER_LEN = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   tmp101_i2c_responder_if.slave        bus,
   input  logic [11:0]                  temp_in,
   output logic [7:0]                   config_out,
   output logic                         busy
`ifdef TMP101_ALERT_EN
   ,
   output logic                         alert_n
`endif
);

   localparam logic [6:0] DEV_ADDR = TMP101_ADDR_BASE | {4'b0000, I2C_ADDR};

   logic sda_f_s, scl_rise_s, scl_fall_s, start_s, stop_s;

   i2c_bus_cond #(.FILTER_LEN(FILTER_LEN)) u_cond (
      .clk         (clk),
      .reset       (reset),
      .scl_i       (bus.scl_i),
      .sda_i       (bus.sda_i),
      .sda_o       (sda_f_s),
      .scl_rise_o  (scl_rise_s),
      .scl_fall_o  (scl_fall_s),
      .start_det_o (start_s),
      .stop_det_o  (stop_s)
   );

   state_e      state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [6:0]  rx_sr_q, rx_sr_d;
   logic [7:0]  tx_sr_q, tx_sr_d;
   logic        sda_t_q, sda_t_d;
   logic        busy_q, busy_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [7:0]  conf_q, conf_d;
   logic [15:0] tlow_q, tlow_d;
   logic [15:0] thigh_q, thigh_d;
   logic [11:0] shadow_q, shadow_d;
   logic        rw_q, rw_d;
   logic        first_q, first_d;
   logic        idx_q, idx_d;
   logic        phase_q, phase_d;

   logic [7:0]  rx_byte_s;
   logic [15:0] word_s;
   logic [7:0]  tx_byte_s;

   assign rx_byte_s = {rx_sr_q, sda_f_s};
   assign tx_byte_s = reg_byte(word_s, idx_q);

   // Register selected by the pointer, as seen by a read.
   always_comb begin
      case (ptr_q)
         PTR_TEMP:  word_s = {shadow_q, 4'b0000};
         PTR_CONF:  word_s = {conf_q, conf_q};
         PTR_TLOW:  word_s = tlow_q;
         PTR_THIGH: word_s = thigh_q;
         default:   word_s = 16'h0000;
      endcase
   end

   // Protocol FSM: next state, shift registers, register writes and SDA drive.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      rx_sr_d   = rx_sr_q;
      tx_sr_d   = tx_sr_q;
      sda_t_d   = sda_t_q;
      busy_d    = busy_q;
      ptr_d     = ptr_q;
      conf_d    = conf_q;
      tlow_d    = tlow_q;
      thigh_d   = thigh_q;
      shadow_d  = shadow_q;
      rw_d      = rw_q;
      first_d   = first_q;
      idx_d     = idx_q;
      phase_d   = phase_q;

      if (stop_s) begin
         state_d = ST_IDLE;
         sda_t_d = 1'b1;
         busy_d  = 1'b0;
      end else if (start_s) begin
         state_d   = ST_ADDR;
         bit_cnt_d = 3'd0;
         sda_t_d   = 1'b1;
         phase_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               sda_t_d = 1'b1;
            end

            ST_ADDR: begin
               if (scl_rise_s) begin
                  rx_sr_d   = rx_byte_s[6:0];
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if (rx_byte_s[7:1] == DEV_ADDR) begin
                        state_d = ST_ADDR_ACK;
                        busy_d  = 1'b1;
                        rw_d    = rx_byte_s[0];
                        first_d = ~rx_byte_s[0];
                        idx_d   = 1'b0;
                        phase_d = 1'b0;
                        if (rx_byte_s[0]) begin
                           shadow_d = temp_in;
                        end else begin
                           shadow_d = shadow_q;
                        end
                     end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        sda_t_d = 1'b1;
                     end
                  end else begin
                     state_d = ST_ADDR;
                  end
               end else begin
                  state_d = ST_ADDR;
               end
            end

            // First fall pulls SDA low for the ACK, second fall ends it.
            ST_ADDR_ACK, ST_RX_ACK: begin
               if (scl_fall_s) begin
                  if (!phase_q) begin
                     sda_t_d = 1'b0;
                     phase_d = 1'b1;
                  end else begin
                     phase_d   = 1'b0;
                     bit_cnt_d = 3'd0;
                     if ((state_q == ST_ADDR_ACK) && rw_q) begin
                        state_d = ST_TX_BYTE;
                        sda_t_d = tx_byte_s[7];
                        tx_sr_d = {tx_byte_s[6:0], 1'b1};
                        idx_d   = ~idx_q;
                     end else begin
                        state_d = ST_RX_BYTE;
                        sda_t_d = 1'b1;
                     end
                  end
               end else begin
                  phase_d = phase_q;
               end
            end

            ST_RX_BYTE: begin
               if (scl_rise_s) begin
                  rx_sr_d   = rx_byte_s[6:0];
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_d = ST_RX_ACK;
                     phase_d = 1'b0;
                     if (first_q) begin
                        ptr_d   = rx_byte_s[1:0];
                        first_d = 1'b0;
                     end else begin
                        idx_d = ~idx_q;
                        case (ptr_q)
                           PTR_CONF: begin
                              if (!idx_q) begin
                                 conf_d = rx_byte_s;
                              end else begin
                                 conf_d = conf_q;
                              end
                           end
                           PTR_TLOW: begin
                              if (!idx_q) begin
                                 tlow_d[15:8] = rx_byte_s;
                              end else begin
                                 tlow_d[7:0] = rx_byte_s;
                              end
                           end
                           PTR_THIGH: begin
                              if (!idx_q) begin
                                 thigh_d[15:8] = rx_byte_s;
                              end else begin
                                 thigh_d[7:0] = rx_byte_s;
                              end
                           end
                           default: begin
                              ptr_d = ptr_q;
                           end
                        endcase
                     end
                  end else begin
                     state_d = ST_RX_BYTE;
                  end
               end else begin
                  state_d = ST_RX_BYTE;
               end
            end

            // The shifter fills with ones, so SDA is released after bit 0.
            ST_TX_BYTE: begin
               if (scl_fall_s) begin
                  sda_t_d = tx_sr_q[7];
                  tx_sr_d = {tx_sr_q[6:0], 1'b1};
               end else if (scl_rise_s) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_d = ST_TX_ACK;
                     phase_d = 1'b0;
                  end else begin
                     state_d = ST_TX_BYTE;
                  end
               end else begin
                  state_d = ST_TX_BYTE;
               end
            end

            ST_TX_ACK: begin
               if (scl_fall_s) begin
                  if (phase_q) begin
                     state_d   = ST_TX_BYTE;
                     bit_cnt_d = 3'd0;
                     sda_t_d   = tx_byte_s[7];
                     tx_sr_d   = {tx_byte_s[6:0], 1'b1};
                     idx_d     = ~idx_q;
                     phase_d   = 1'b0;
                  end else begin
                     sda_t_d = 1'b1;
                  end
               end else if (scl_rise_s) begin
                  if (sda_f_s) begin
                     state_d = ST_IDLE;
                     busy_d  = 1'b0;
                     sda_t_d = 1'b1;
                  end else begin
                     phase_d = 1'b1;
                  end
               end else begin
                  phase_d = phase_q;
               end
            end

            default: begin
               state_d = ST_IDLE;
               sda_t_d = 1'b1;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   // FSM and register file state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= 3'd0;
         rx_sr_q   <= 7'd0;
         tx_sr_q   <= 8'hFF;
         sda_t_q   <= 1'b1;
         busy_q    <= 1'b0;
         ptr_q     <= PTR_TEMP;
         conf_q    <= CONF_RESET;
         tlow_q    <= TLOW_RESET;
         thigh_q   <= THIGH_RESET;
         shadow_q  <= 12'h000;
         rw_q      <= 1'b0;
         first_q   <= 1'b0;
         idx_q     <= 1'b0;
         phase_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         rx_sr_q   <= rx_sr_d;
         tx_sr_q   <= tx_sr_d;
         sda_t_q   <= sda_t_d;
         busy_q    <= busy_d;
         ptr_q     <= ptr_d;
         conf_q    <= conf_d;
         tlow_q    <= tlow_d;
         thigh_q   <= thigh_d;
         shadow_q  <= shadow_d;
         rw_q      <= rw_d;
         first_q   <= first_d;
         idx_q     <= idx_d;
         phase_q   <= phase_d;
      end
   end

   assign bus.sda_t  = sda_t_q;
   assign config_out = conf_q;
   assign busy       = busy_q;

`ifdef TMP101_ALERT_EN
   logic        act_q, act_d;
   logic        alert_n_q, alert_n_d;
   logic [15:0] temp_ext_s;

   assign temp_ext_s = {temp_in, 4'b0000};

   // Comparator mode: T_HIGH sets the alert, below T_LOW clears it, POL inverts.
   always_comb begin
      if ($signed(temp_ext_s) >= $signed(thigh_q)) begin
         act_d = 1'b1;
      end else if ($signed(temp_ext_s) < $signed(tlow_q)) begin
         act_d = 1'b0;
      end else begin
         act_d = act_q;
      end
      alert_n_d = conf_q[2] ? act_d : ~act_d;
   end

   // Alert state and output register.
   always_ff @(posedge clk) begin
      if (reset) begin
         act_q     <= 1'b0;
         alert_n_q <= 1'b1;
      end else begin
         act_q     <= act_d;
         alert_n_q <= alert_n_d;
      end
   end

   assign alert_n = alert_n_q;
`endif

endmodule

// File: tb/tb_tmp101_i2c_responder.sv
// Directed bench for tmp101_i2c_responder: bit-banged I2C master with
// hand-computed expected register values.
module tb_tmp101_i2c_responder;

   localparam int Q = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        m_scl = 1'b1;
   logic        m_sda = 1'b1;
   logic [11:0] temp_in = 12'h190;
   logic [7:0]  config_out;
   logic        busy;
`ifdef TMP101_ALERT_EN
   logic        alert_n;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   tmp101_i2c_responder_if bus();

   assign bus.scl_i = m_scl;
   assign bus.sda_i = m_sda & bus.sda_t;

   tmp101_i2c_responder #(.I2C_ADDR(3'b000), .FILTER_LEN(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .temp_in    (temp_in),
      .config_out (config_out),
      .busy       (busy)
`ifdef TMP101_ALERT_EN
      ,
      .alert_n    (alert_n)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; tick(Q);
      m_scl = 1'b1; tick(Q);
      m_sda = 1'b0; tick(Q);
      m_scl = 1'b0; tick(Q);
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; tick(Q);
      m_scl = 1'b1; tick(Q);
      m_sda = 1'b1; tick(Q);
   endtask

   task automatic send_bit(input logic b);
      m_sda = b;    tick(Q);
      m_scl = 1'b1; tick(2 * Q);
      m_scl = 1'b0; tick(Q);
   endtask

   // Sends a byte; the ACK slot is watched for any low level on the bus.
   task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string tag);
      logic seen_low;
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      m_sda = 1'b1;
      seen_low = 1'b0;
      repeat (Q) begin
         @(negedge clk);
         if (bus.sda_i === 1'b0) seen_low = 1'b1;
      end
      m_scl = 1'b1;
      repeat (2 * Q) begin
         @(negedge clk);
         if (bus.sda_i === 1'b0) seen_low = 1'b1;
      end
      m_scl = 1'b0; tick(Q);
      check(tag, {15'd0, seen_low}, {15'd0, exp_ack});
   endtask

   task automatic read_byte(input logic mack, input logic [7:0] exp, input string tag);
      logic [7:0] b;
      m_sda = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         tick(Q);
         m_scl = 1'b1; tick(Q);
         b[i] = bus.sda_i; tick(Q);
         m_scl = 1'b0; tick(Q);
      end
      send_bit(~mack);
      m_sda = 1'b1;
      check(tag, {8'd0, b}, {8'd0, exp});
   endtask

   initial begin
      tick(4);
      check("rst_sda_t", {15'd0, bus.sda_t}, 16'h0001);
      check("rst_busy", {15'd0, busy}, 16'h0000);
      check("rst_config", {8'd0, config_out}, 16'h0000);
      reset = 1'b0;
      tick(Q);

      // Pointer write to temperature, repeated START, two-byte read.
      i2c_start();
      write_byte(8'h90, 1'b1, "t1_addr_w_ack");
      check("t1_busy_set", {15'd0, busy}, 16'h0001);
      write_byte(8'h00, 1'b1, "t1_ptr_ack");
      i2c_start();
      write_byte(8'h91, 1'b1, "t1_addr_r_ack");
      read_byte(1'b1, 8'h19, "t1_rd_msb");
      read_byte(1'b0, 8'h00, "t1_rd_lsb");
      check("t1_busy_clr", {15'd0, busy}, 16'h0000);
      check("t1_sda_rel", {15'd0, bus.sda_t}, 16'h0001);
      i2c_stop();
      tick(Q);

      // Wrong address (0x4A) is ignored until the next START.
      i2c_start();
      write_byte(8'h94, 1'b0, "t2_addr_nack");
      check("t2_busy", {15'd0, busy}, 16'h0000);
      write_byte(8'h90, 1'b0, "t2_idle_nack");
      check("t2_busy_idle", {15'd0, busy}, 16'h0000);
      i2c_stop();
      tick(Q);

      // STOP in the middle of the pointer byte leaves the pointer alone.
      i2c_start();
      write_byte(8'h90, 1'b1, "t5_addr_ack");
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      i2c_stop();
      check("t5_busy", {15'd0, busy}, 16'h0000);
      check("t5_sda_rel", {15'd0, bus.sda_t}, 16'h0001);
      i2c_start();
      write_byte(8'h91, 1'b1, "t5_addr_r_ack");
      read_byte(1'b1, 8'h19, "t5_rd_msb");
      read_byte(1'b0, 8'h00, "t5_rd_lsb");
      i2c_stop();
      tick(Q);

      // Single-clock SDA glitch with SCL high must not look like a START.
      m_sda = 1'b0; tick(1);
      m_sda = 1'b1; tick(Q);
      check("t5_glitch_busy", {15'd0, busy}, 16'h0000);
      m_scl = 1'b0; tick(Q);
      write_byte(8'h90, 1'b0, "t5_glitch_nack");
      check("t5_glitch_busy2", {15'd0, busy}, 16'h0000);
      i2c_stop();
      tick(Q);

      // Config write then read; config repeats for every byte index.
      i2c_start();
      write_byte(8'h90, 1'b1, "t3_addr_ack");
      write_byte(8'h01, 1'b1, "t3_ptr_ack");
      write_byte(8'h60, 1'b1, "t3_data_ack");
      i2c_stop();
      check("t3_config", {8'd0, config_out}, 16'h0060);
      i2c_start();
      write_byte(8'h91, 1'b1, "t3_addr_r_ack");
      read_byte(1'b1, 8'h60, "t3_rd0");
      read_byte(1'b0, 8'h60, "t3_rd1");
      i2c_stop();
      tick(Q);

      // T_HIGH = 25 C; T_LOW keeps its reset value.
      temp_in = 12'h180;
      i2c_start();
      write_byte(8'h90, 1'b1, "t4_addr_ack");
      write_byte(8'h03, 1'b1, "t4_ptr_ack");
      write_byte(8'h19, 1'b1, "t4_msb_ack");
      write_byte(8'h00, 1'b1, "t4_lsb_ack");
      i2c_stop();
      i2c_start();
      write_byte(8'h91, 1'b1, "t4_rd_addr_ack");
      read_byte(1'b1, 8'h19, "t4_thigh_msb");
      read_byte(1'b0, 8'h00, "t4_thigh_lsb");
      i2c_stop();
      i2c_start();
      write_byte(8'h90, 1'b1, "t4_addr2_ack");
      write_byte(8'h02, 1'b1, "t4_ptr2_ack");
      i2c_start();
      write_byte(8'h91, 1'b1, "t4_rd2_addr_ack");
      read_byte(1'b1, 8'h4B, "t4_tlow_msb");
      read_byte(1'b0, 8'h00, "t4_tlow_lsb");
      i2c_stop();
`ifdef TMP101_ALERT_EN
      check("t4_alert_idle", {15'd0, alert_n}, 16'h0001);
      temp_in = 12'h1A0;
      tick(2);
      check("t4_alert_fall", {15'd0, alert_n}, 16'h0000);
`else
      temp_in = 12'h1A0;
`endif
      tick(Q);

      // Reset while the responder drives a 0 data bit (T_LOW MSB = 0x4B).
      i2c_start();
      write_byte(8'h91, 1'b1, "t6_addr_ack");
      check("t6_driving", {15'd0, bus.sda_t}, 16'h0000);
      check("t6_busy_pre", {15'd0, busy}, 16'h0001);
      check("t6_config_pre", {8'd0, config_out}, 16'h0060);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("t6_sda_rel", {15'd0, bus.sda_t}, 16'h0001);
      check("t6_config_rst", {8'd0, config_out}, 16'h0000);
      check("t6_busy_rst", {15'd0, busy}, 16'h0000);
      @(negedge clk);
      reset = 1'b0;
      tick(Q);
      i2c_stop();
      tick(Q);

      // Pointer is back to temperature after reset: {0x1A0, 4'b0}.
      i2c_start();
      write_byte(8'h91, 1'b1, "t6_rd_addr_ack");
      read_byte(1'b1, 8'h1A, "t6_temp_msb");
      read_byte(1'b0, 8'h00, "t6_temp_lsb");
      i2c_stop();
      tick(Q);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
